seg_scan_scheduler: RTL and testbench

Sequences the 4-digit 7-segment display path. Generates the digit-select index consumed by the display decoder and requests a binary-to-BCD conversion once per frame for the currently selected accelerometer axis. Latches the returned digits tear-free at frame boundaries and rotates the axis X->Y->Z on a frame count. Sits between the axis-data/BCD converter and the display decoder.

---
 rtl/disp_pkg.sv | 35 +++
 rtl/scan_prescaler.sv | 54 +++++
 rtl/seg_scan_scheduler.sv | 144 ++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : disp_pkg
// Description : Shared definitions for the 4-digit 7-segment scan path:
//               axis codes, conversion-sequencer state encoding, the
//               digit-slot index width and a packed 4-digit BCD bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Width of the digit-slot index (4 slots).
    localparam int ARRAY_W = 2;

    // Axis codes presented on axis_sel.
    localparam logic [1:0] AXIS_X = 2'd0;
    localparam logic [1:0] AXIS_Y = 2'd1;
    localparam logic [1:0] AXIS_Z = 2'd2;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PENDING = 2'd2
    } conv_state_t;

    // Four BCD digits, most significant first.
    typedef struct packed {
        logic [3:0] thousands;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd4_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Digit-slot timebase. A prescaler counts 0..REFRESH_DIV-1;
//               each terminal count advances the slot index, which wraps
//               3->0. frame_tick is a registered pulse in the cycle after
//               the 3->0 wrap edge. frame_wrap is the combinational
//               "next edge wraps" strobe, so the parent can register its
//               own outputs to change in the same cycle as frame_tick.
// Ports       : clk, reset_n (sync, active low)
//               array      - current digit slot (registered)
//               frame_tick - one-cycle pulse after the 3->0 wrap (registered)
//               frame_wrap - high in the cycle whose closing edge wraps
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [ARRAY_W-1:0] array,
    output logic               frame_tick,
    output logic               frame_wrap
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic          slot_end;

    assign slot_end   = (prescaler == PRE_LAST);
    assign frame_wrap = slot_end && (array == ARRAY_W'(3));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler  <= '0;
            array      <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (slot_end) begin
                prescaler <= '0;
                array     <= array + ARRAY_W'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_scheduler
// Description : Sequences the 7-segment display path. Requests one BCD
//               conversion per frame for the selected axis, captures the
//               result in a shadow register, and moves it to the display
//               digits only at a frame boundary (no tearing). Rotates the
//               axis every FRAMES_PER_AXIS frames unless hold is set.
// Ports       : clk, reset_n (sync, active low), hold
//               conv_done, conv_ones..conv_thousands - converter result
//               conv_start, axis_sel                 - converter request
//               array, ones..thousands, frame_tick   - display decoder
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_scheduler
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV     = 100000,
    parameter int FRAMES_PER_AXIS = 250,
    parameter int NUM_AXES        = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hold,
    input  logic               conv_done,
    input  logic [3:0]         conv_ones,
    input  logic [3:0]         conv_tens,
    input  logic [3:0]         conv_hundreds,
    input  logic [3:0]         conv_thousands,
    output logic               conv_start,
    output logic [1:0]         axis_sel,
    output logic [ARRAY_W-1:0] array,
    output logic [3:0]         ones,
    output logic [3:0]         tens,
    output logic [3:0]         hundreds,
    output logic [3:0]         thousands,
    output logic               frame_tick
);

    localparam int FCW = (FRAMES_PER_AXIS > 1) ? $clog2(FRAMES_PER_AXIS) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_AXIS - 1);
    localparam logic [1:0]     AXIS_LAST  = 2'(NUM_AXES - 1);

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic frame_wrap;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .array      (array),
        .frame_tick (frame_tick),
        .frame_wrap (frame_wrap)
    );

    // ------------------------------------------------------------------
    // Sequencer, shadow register and axis rotation.
    // Every decision keyed on frame_wrap lands at the same edge that
    // raises frame_tick, so conv_start, digit updates and axis changes
    // all appear in the frame_tick cycle while staying registered.
    // ------------------------------------------------------------------
    conv_state_t     state, state_next;
    bcd4_t           shadow, shadow_next;
    bcd4_t           digits, digits_next;
    logic [FCW-1:0]  frame_cnt, frame_cnt_next;
    logic [1:0]      axis_next;
    logic            conv_start_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            shadow     <= '0;
            digits     <= '0;
            frame_cnt  <= '0;
            axis_sel   <= AXIS_X;
            conv_start <= 1'b0;
        end else begin
            state      <= state_next;
            shadow     <= shadow_next;
            digits     <= digits_next;
            frame_cnt  <= frame_cnt_next;
            axis_sel   <= axis_next;
            conv_start <= conv_start_next;
        end
    end

    always_comb begin
        state_next      = state;
        shadow_next     = shadow;
        digits_next     = digits;
        frame_cnt_next  = frame_cnt;
        axis_next       = axis_sel;
        conv_start_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (frame_wrap) begin
                    conv_start_next = 1'b1;
                    state_next      = CONVERT;
                end
            end
            CONVERT: begin
                // Frame boundaries are ignored here: one request in flight.
                if (conv_done) begin
                    shadow_next = '{thousands: conv_thousands,
                                    hundreds:  conv_hundreds,
                                    tens:      conv_tens,
                                    ones:      conv_ones};
                    state_next  = PENDING;
                end
            end
            PENDING: begin
                if (frame_wrap) begin
                    digits_next     = shadow;
                    conv_start_next = 1'b1;
                    state_next      = CONVERT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (frame_wrap && !hold) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt_next = '0;
                axis_next      = (axis_sel == AXIS_LAST) ? AXIS_X
                                                         : axis_sel + 2'd1;
            end else begin
                frame_cnt_next = frame_cnt + FCW'(1);
            end
        end
    end

    assign thousands = digits.thousands;
    assign hundreds  = digits.hundreds;
    assign tens      = digits.tens;
    assign ones      = digits.ones;

endmodule : seg_scan_scheduler
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_scheduler
// Description : Randomized self-checking bench. A reference model derives
//               every cycle's expected outputs from the elapsed cycle count
//               since reset and a small per-frame conversion bookkeeping;
//               expectations are queued and a monitor compares them with
//               the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_scheduler;

    localparam int R   = 4;   // REFRESH_DIV
    localparam int FPA = 2;   // FRAMES_PER_AXIS
    localparam int NAX = 3;   // NUM_AXES

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hold = 1'b0;
    logic       conv_done = 1'b0;
    logic [3:0] conv_ones = '0, conv_tens = '0, conv_hundreds = '0, conv_thousands = '0;
    logic       conv_start;
    logic [1:0] axis_sel;
    logic [1:0] array;
    logic [3:0] ones, tens, hundreds, thousands;
    logic       frame_tick;

    seg_scan_scheduler #(
        .REFRESH_DIV     (R),
        .FRAMES_PER_AXIS (FPA),
        .NUM_AXES        (NAX)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hold           (hold),
        .conv_done      (conv_done),
        .conv_ones      (conv_ones),
        .conv_tens      (conv_tens),
        .conv_hundreds  (conv_hundreds),
        .conv_thousands (conv_thousands),
        .conv_start     (conv_start),
        .axis_sel       (axis_sel),
        .array          (array),
        .ones           (ones),
        .tens           (tens),
        .hundreds       (hundreds),
        .thousands      (thousands),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  arr;
        logic        ft;
        logic        cs;
        logic [1:0]  ax;
        logic [15:0] dig;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // ------------------------------------------------------------------
    // Reference model: everything follows from k = edges since reset.
    // busy  : a request is outstanding (answer expected)
    // have  : an answer is waiting for the next frame boundary
    // ------------------------------------------------------------------
    int         m_k = 0;
    bit         m_busy = 0, m_have = 0;
    logic [15:0] m_shadow = '0, m_digits = '0;
    int         m_fc = 0, m_axis = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   ft, cs, was_busy;
        ft = 0; cs = 0;
        if (!reset_n) begin
            m_k = 0; m_busy = 0; m_have = 0;
            m_shadow = '0; m_digits = '0; m_fc = 0; m_axis = 0;
        end else begin
            m_k++;
            ft = (m_k % (4 * R)) == 0;
            was_busy = m_busy;
            if (was_busy && conv_done) begin
                m_shadow = {conv_thousands, conv_hundreds, conv_tens, conv_ones};
                m_busy = 0;
                m_have = 1;
            end
            if (ft && !was_busy) begin
                if (m_have) begin
                    m_digits = m_shadow;
                    m_have = 0;
                end
                cs = 1;
                m_busy = 1;
            end
            if (ft && !hold) begin
                if (m_fc == FPA - 1) begin
                    m_fc = 0;
                    m_axis = (m_axis + 1) % NAX;
                end else begin
                    m_fc++;
                end
            end
        end
        e.arr = 2'((m_k / R) % 4);
        e.ft  = ft;
        e.cs  = cs;
        e.ax  = 2'(m_axis);
        e.dig = m_digits;
        exp_q.push_back(e);
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty at t=%0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            check("array",      16'(array),      16'(e.arr));
            check("frame_tick", 16'(frame_tick), 16'(e.ft));
            check("conv_start", 16'(conv_start), 16'(e.cs));
            check("axis_sel",   16'(axis_sel),   16'(e.ax));
            check("digits",     {thousands, hundreds, tens, ones}, e.dig);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: converter responder with random latency plus phases.
    // ------------------------------------------------------------------
    bit silent = 0, spurious = 1, hold_rand = 0;
    int lat_max = 6;
    int delay = -1;

    task automatic step();
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        if (hold_rand) hold = 1'($urandom_range(0, 1));
        if (!reset_n) begin
            delay = -1;
        end else begin
            if (!silent && m_busy && delay < 0) delay = $urandom_range(1, lat_max);
            if (delay > 0 && !silent) begin
                delay--;
                if (delay == 0) begin
                    conv_done = 1'b1;
                    delay = -1;
                end
            end
            if (!m_busy && spurious && $urandom_range(0, 9) == 0) conv_done = 1'b1;
        end
        conv_ones      = 4'($urandom_range(0, 9));
        conv_tens      = 4'($urandom_range(0, 9));
        conv_hundreds  = 4'($urandom_range(0, 9));
        conv_thousands = 4'($urandom_range(0, 9));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;

        // Normal operation, quick answers, spurious pulses when idle/pending.
        run(240);

        // Rotation frozen for more than 5 frames.
        hold = 1'b1;
        run(96);
        hold = 1'b0;
        run(40);

        // Converter silent for over 3 frames, then a late answer.
        silent = 1;
        run(56);
        silent = 0;
        lat_max = 3;
        run(60);

        // Random hold and long latencies spanning frame boundaries.
        hold_rand = 1;
        lat_max = 40;
        run(320);
        hold_rand = 0;
        hold = 1'b0;

        // Reset while a conversion is outstanding; answer arrives too late.
        silent = 1;
        spurious = 0;
        guard = 0;
        while (!m_busy && guard < 100) begin
            step();
            guard++;
        end
        if (!m_busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_busy: got idle expected outstanding request");
        end
        run(3);
        @(posedge clk); #1;
        reset_n = 1'b0;
        conv_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
        run(30);
        silent = 0;
        spurious = 1;
        lat_max = 5;
        run(80);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seg_scan_scheduler
`default_nettype wire
